// File: rtl/sa_cache.sv
// rtl/sa_cache.sv - set-associative write-back cache, LRU replacement, word-wide CPU port
module sa_cache #(
    parameter int WAYS       = 4,
    parameter int SETS       = 256,
    parameter int LINE_WORDS = 16,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_BITS   = 18,
    localparam int IDX = $clog2(SETS),
    localparam int OFF = $clog2(LINE_WORDS),
    localparam int AW  = $clog2(WAYS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_req_valid,
    output logic                         o_req_ready,
    input  logic                         i_req_we,
    input  logic [TAG_BITS-1:0]          i_tag,
    input  logic [IDX-1:0]               i_index,
    input  logic [OFF-1:0]               i_offset,
    input  logic [DATA_WIDTH-1:0]        i_wdata,
    output logic                         o_resp_valid,
    output logic [DATA_WIDTH-1:0]        o_data,
    output logic                         o_cache_hit,
    output logic                         o_mem_valid,
    input  logic                         i_mem_ready,
    output logic                         o_mem_we,
    output logic [TAG_BITS+IDX+OFF-1:0]  o_mem_addr,
    output logic [DATA_WIDTH-1:0]        o_mem_wdata,
    input  logic                         i_mem_rvalid,
    input  logic [DATA_WIDTH-1:0]        i_mem_rdata
);

    typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL_REQ, REFILL, RESPOND} state_t;
    localparam logic [OFF-1:0] LAST_BEAT = OFF'(LINE_WORDS - 1);

    state_t state, state_nx;

    logic [WAYS-1:0]       valid_r [SETS];
    logic [WAYS-1:0]       dirty_r [SETS];
    logic [AW-1:0]         age_r   [SETS][WAYS];
    logic [TAG_BITS-1:0]   tag_r   [SETS][WAYS];
    logic [DATA_WIDTH-1:0] data_mem [WAYS*SETS*LINE_WORDS];

    logic                  req_we;
    logic [TAG_BITS-1:0]   req_tag;
    logic [IDX-1:0]        req_idx;
    logic [OFF-1:0]        req_off;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  hit_q;
    logic [AW-1:0]         way_q;
    logic [OFF-1:0]        beat;

    logic                  hit;
    logic [AW-1:0]         hit_way, victim;
    logic                  wr_en;
    logic [AW+IDX+OFF-1:0] wr_addr, rd_addr;
    logic [DATA_WIDTH-1:0] wr_data, rd_data;
    logic                  last_refill;

    assign rd_addr     = {way_q, req_idx, (state == WRITEBACK) ? beat : req_off};
    assign rd_data     = data_mem[rd_addr];
    assign last_refill = (state == REFILL) && i_mem_rvalid && (beat == LAST_BEAT);

    // Victim: lowest invalid way first, otherwise the way holding the oldest age.
    always_comb begin
        logic found;
        hit     = 1'b0;
        hit_way = '0;
        victim  = '0;
        found   = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_r[req_idx][w] && tag_r[req_idx][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = AW'(w);
            end
            if (!valid_r[req_idx][w] && !found) begin
                victim = AW'(w);
                found  = 1'b1;
            end
        end
        if (!found) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_r[req_idx][w] == AW'(WAYS - 1)) victim = AW'(w);
            end
        end
    end

    always_comb begin
        state_nx     = state;
        o_req_ready  = 1'b0;
        o_resp_valid = 1'b0;
        o_cache_hit  = 1'b0;
        o_data       = '0;
        o_mem_valid  = 1'b0;
        o_mem_we     = 1'b0;
        o_mem_addr   = '0;
        o_mem_wdata  = '0;
        wr_en        = 1'b0;
        wr_addr      = {way_q, req_idx, req_off};
        wr_data      = req_wdata;
        case (state)
            IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) state_nx = LOOKUP;
            end
            LOOKUP: begin
                if (hit)                                               state_nx = RESPOND;
                else if (valid_r[req_idx][victim] && dirty_r[req_idx][victim]) state_nx = WRITEBACK;
                else                                                   state_nx = REFILL_REQ;
            end
            WRITEBACK: begin
                o_mem_valid = 1'b1;
                o_mem_we    = 1'b1;
                o_mem_addr  = {tag_r[req_idx][way_q], req_idx, beat};
                o_mem_wdata = rd_data;
                if (i_mem_ready && beat == LAST_BEAT) state_nx = REFILL_REQ;
            end
            REFILL_REQ: begin
                o_mem_valid = 1'b1;
                o_mem_addr  = {req_tag, req_idx, {OFF{1'b0}}};
                if (i_mem_ready) state_nx = REFILL;
            end
            REFILL: begin
                if (i_mem_rvalid) begin
                    wr_en   = 1'b1;
                    wr_addr = {way_q, req_idx, beat};
                    wr_data = i_mem_rdata;
                end
                if (last_refill) state_nx = RESPOND;
            end
            RESPOND: begin
                o_resp_valid = 1'b1;
                o_cache_hit  = hit_q;
                o_data       = rd_data;
                wr_en        = req_we;
                state_nx     = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            beat      <= '0;
            req_we    <= 1'b0;
            req_tag   <= '0;
            req_idx   <= '0;
            req_off   <= '0;
            req_wdata <= '0;
            hit_q     <= 1'b0;
            way_q     <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_r[s] <= '0;
                dirty_r[s] <= '0;
                for (int w = 0; w < WAYS; w++) age_r[s][w] <= AW'(w);
            end
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (i_req_valid) begin
                    req_we    <= i_req_we;
                    req_tag   <= i_tag;
                    req_idx   <= i_index;
                    req_off   <= i_offset;
                    req_wdata <= i_wdata;
                end
                LOOKUP: begin
                    hit_q <= hit;
                    way_q <= hit ? hit_way : victim;
                end
                WRITEBACK: if (i_mem_ready) beat <= beat + 1'b1;
                REFILL: if (i_mem_rvalid) begin
                    beat <= beat + 1'b1;
                    if (beat == LAST_BEAT) begin
                        valid_r[req_idx][way_q] <= 1'b1;
                        dirty_r[req_idx][way_q] <= 1'b0;
                    end
                end
                RESPOND: begin
                    if (req_we) dirty_r[req_idx][way_q] <= 1'b1;
                    for (int w = 0; w < WAYS; w++) begin
                        if (AW'(w) == way_q)
                            age_r[req_idx][w] <= '0;
                        else if (age_r[req_idx][w] < age_r[req_idx][way_q])
                            age_r[req_idx][w] <= age_r[req_idx][w] + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Data and tag arrays carry no reset; valid bits gate every use of them.
    always_ff @(posedge clk) begin
        if (wr_en) data_mem[wr_addr] <= wr_data;
        if (last_refill) tag_r[req_idx][way_q] <= req_tag;
    end

endmodule

// File: tb/tb_sa_cache.sv
// tb/tb_sa_cache.sv - scoreboard bench for sa_cache with a recency-list reference model
module tb_sa_cache;
    localparam int WAYS = 4, SETS = 256, LW = 16, DW = 32, TB = 18;
    localparam int IDX = 8, OFF = 4, AD = TB + IDX + OFF;

    logic clk, rst;
    logic i_req_valid, o_req_ready, i_req_we;
    logic [TB-1:0] i_tag;
    logic [IDX-1:0] i_index;
    logic [OFF-1:0] i_offset;
    logic [DW-1:0] i_wdata, o_data, o_mem_wdata, i_mem_rdata;
    logic o_resp_valid, o_cache_hit, o_mem_valid, i_mem_ready, o_mem_we, i_mem_rvalid;
    logic [AD-1:0] o_mem_addr;

    sa_cache #(.WAYS(WAYS), .SETS(SETS), .LINE_WORDS(LW), .DATA_WIDTH(DW), .TAG_BITS(TB)) dut (
        .clk(clk), .rst(rst), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_we(i_req_we), .i_tag(i_tag), .i_index(i_index), .i_offset(i_offset),
        .i_wdata(i_wdata), .o_resp_valid(o_resp_valid), .o_data(o_data),
        .o_cache_hit(o_cache_hit), .o_mem_valid(o_mem_valid), .i_mem_ready(i_mem_ready),
        .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata));

    typedef struct { logic [DW-1:0] data; bit hit; int acc; } resp_t;
    typedef struct { bit we; logic [AD-1:0] addr; logic [DW-1:0] data; } memop_t;
    typedef struct { logic [TB-1:0] tag; bit dirty; logic [LW-1:0][DW-1:0] w; } line_t;

    resp_t  rq[$];
    memop_t mq[$];
    line_t  lru [SETS][$];               // per set, most recently used first
    logic [DW-1:0] mdl_mem [logic [AD-1:0]];
    logic [DW-1:0] bmem    [logic [AD-1:0]];

    int n_tests = 0, n_fail = 0, cyc = 0;
    int refill_left = 0, rbeat = -1, stall_wb = 0, stall_rr = 0, wb_cnt = 0;
    logic [AD-1:0] refill_base;
    logic [DW-1:0] wb_seen [LW];
    logic [AD-1:0] wb_addr_seen [LW];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] init_word(input logic [AD-1:0] a);
        return DW'(a) * 32'h9E37_79B1 + 32'h1234_5677;
    endfunction

    function automatic logic [DW-1:0] mdl_rd(input logic [AD-1:0] a);
        return mdl_mem.exists(a) ? mdl_mem[a] : init_word(a);
    endfunction

    function automatic logic [DW-1:0] bmem_rd(input logic [AD-1:0] a);
        return bmem.exists(a) ? bmem[a] : init_word(a);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_msg(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event missing or unexpected (cycle %0d)", name, cyc);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req_ready", 64'(o_req_ready), 64'd1);
        chk("rst_resp_valid", 64'(o_resp_valid), 64'd0);
        chk("rst_cache_hit", 64'(o_cache_hit), 64'd0);
        chk("rst_data", 64'(o_data), 64'd0);
        chk("rst_mem_valid", 64'(o_mem_valid), 64'd0);
        chk("rst_mem_we", 64'(o_mem_we), 64'd0);
        chk("rst_mem_addr", 64'(o_mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(o_mem_wdata), 64'd0);
    endtask

    task automatic model_req(input logic [TB-1:0] tag, input logic [IDX-1:0] idx,
                             input logic [OFF-1:0] off, input bit we,
                             input logic [DW-1:0] wd, input int acc);
        line_t ln, vic;
        memop_t m;
        resp_t r;
        int pos = -1;
        for (int i = 0; i < lru[idx].size(); i++) if (lru[idx][i].tag == tag) pos = i;
        r.hit = (pos >= 0);
        if (pos >= 0) begin
            ln = lru[idx][pos];
            lru[idx].delete(pos);
        end else begin
            if (lru[idx].size() == WAYS) begin
                vic = lru[idx].pop_back();
                if (vic.dirty) for (int b = 0; b < LW; b++) begin
                    m.we = 1'b1; m.addr = {vic.tag, idx, OFF'(b)}; m.data = vic.w[b];
                    mq.push_back(m);
                    mdl_mem[m.addr] = vic.w[b];
                end
            end
            m.we = 1'b0; m.addr = {tag, idx, {OFF{1'b0}}}; m.data = '0;
            mq.push_back(m);
            ln.tag = tag; ln.dirty = 1'b0;
            for (int b = 0; b < LW; b++) ln.w[b] = mdl_rd({tag, idx, OFF'(b)});
        end
        r.data = ln.w[off];
        r.acc  = acc;
        if (we) begin ln.w[off] = wd; ln.dirty = 1'b1; end
        lru[idx].push_front(ln);
        rq.push_back(r);
    endtask

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) lru[s].delete();
        rq.delete();
        mq.delete();
    endtask

    task automatic send(input logic [TB-1:0] tag, input logic [IDX-1:0] idx,
                        input logic [OFF-1:0] off, input bit we, input logic [DW-1:0] wd);
        int t = 0;
        @(negedge clk);
        i_req_valid = 1'b1; i_req_we = we; i_tag = tag; i_index = idx;
        i_offset = off; i_wdata = wd;
        while (!o_req_ready && t < 200) begin @(negedge clk); t++; end
        if (!o_req_ready) fail_msg("req_ready_timeout");
        else model_req(tag, idx, off, we, wd, cyc);
        @(negedge clk);
        i_req_valid = 1'b0;
    endtask

    task automatic wait_resp();
        int t = 0;
        while (rq.size() > 0 && t < 1000) begin @(negedge clk); t++; end
        if (rq.size() > 0) begin fail_msg("resp_timeout"); rq.delete(); end
    endtask

    // Response monitor
    initial begin
        resp_t r;
        forever begin
            @(negedge clk);
            if (!rst && o_resp_valid) begin
                if (rq.size() == 0) fail_msg("unexpected_resp");
                else begin
                    r = rq.pop_front();
                    chk("resp_data", 64'(o_data), 64'(r.data));
                    chk("resp_hit", 64'(o_cache_hit), 64'(r.hit));
                    if (r.hit) chk("hit_latency", 64'(cyc - r.acc), 64'd2);
                end
            end
        end
    end

    // Memory responder: random ready, gapped refill beats, stray rvalid noise
    initial begin
        bit prev_stall = 1'b0, rdy;
        logic [AD-1:0] p_addr;
        logic p_we;
        logic [DW-1:0] p_wd;
        memop_t m;
        int b;
        i_mem_ready = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                refill_left = 0; i_mem_rvalid = 1'b0; i_mem_ready = 1'b0; prev_stall = 1'b0;
            end else begin
                if (refill_left > 0) begin
                    i_mem_rvalid = ($urandom_range(0, 3) != 0);
                    if (i_mem_rvalid) begin
                        b = LW - refill_left;
                        i_mem_rdata = bmem_rd(refill_base + AD'(b));
                        rbeat = b;
                        refill_left--;
                    end
                end else begin
                    i_mem_rvalid = ($urandom_range(0, 7) == 0);
                    i_mem_rdata  = $urandom();
                end
                if (prev_stall && o_mem_valid) begin
                    chk("stall_addr_stable", 64'(o_mem_addr), 64'(p_addr));
                    chk("stall_we_stable", 64'(o_mem_we), 64'(p_we));
                    if (p_we) chk("stall_wdata_stable", 64'(o_mem_wdata), 64'(p_wd));
                end
                if (o_mem_valid && o_mem_we && stall_wb > 0) begin rdy = 1'b0; stall_wb--; end
                else if (o_mem_valid && !o_mem_we && stall_rr > 0) begin rdy = 1'b0; stall_rr--; end
                else rdy = ($urandom_range(0, 2) != 0);
                i_mem_ready = rdy;
                if (o_mem_valid && rdy) begin
                    if (mq.size() == 0) fail_msg("unexpected_mem_op");
                    else begin
                        m = mq.pop_front();
                        chk("mem_we", 64'(o_mem_we), 64'(m.we));
                        chk("mem_addr", 64'(o_mem_addr), 64'(m.addr));
                        if (m.we) chk("wb_data", 64'(o_mem_wdata), 64'(m.data));
                    end
                    if (o_mem_we) begin
                        bmem[o_mem_addr] = o_mem_wdata;
                        wb_seen[o_mem_addr[OFF-1:0]] = o_mem_wdata;
                        wb_addr_seen[o_mem_addr[OFF-1:0]] = o_mem_addr;
                        wb_cnt++;
                    end else begin
                        refill_left = LW;
                        refill_base = o_mem_addr;
                    end
                end
                prev_stall = o_mem_valid && !rdy;
                p_addr = o_mem_addr; p_we = o_mem_we; p_wd = o_mem_wdata;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: run exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        logic [AD-1:0] exp_a;
        rst = 1'b1; i_req_valid = 1'b0; i_req_we = 1'b0; i_tag = '0; i_index = '0;
        i_offset = '0; i_wdata = '0;
        repeat (3) @(negedge clk);
        chk_reset_outputs();
        rst = 1'b0;
        @(negedge clk);
        chk("idle_req_ready", 64'(o_req_ready), 64'd1);

        send(18'h1, 8'd5, 4'd3, 1'b0, '0);      // cold miss, refill of {1,5,0}
        wait_resp();
        chk("miss_memops_drained", 64'(mq.size()), 64'd0);
        send(18'h1, 8'd5, 4'd3, 1'b0, '0);      // hit, latency 2, no memory traffic
        wait_resp();

        send(18'h1, 8'd5, 4'd3, 1'b1, 32'hDEAD_BEEF);
        wait_resp();
        for (int tg = 2; tg <= 4; tg++) begin send(TB'(tg), 8'd5, 4'(tg), 1'b0, '0); wait_resp(); end
        wb_cnt = 0; stall_wb = 10; stall_rr = 10;
        send(18'h5, 8'd5, 4'd0, 1'b0, '0);      // evicts dirty tag 1 under long stalls
        wait_resp();
        chk("evict_wb_beats", 64'(wb_cnt), 64'd16);
        chk("evict_beat3_data", 64'(wb_seen[3]), 64'hDEAD_BEEF);
        exp_a = {18'h1, 8'd5, 4'd3};
        chk("evict_beat3_addr", 64'(wb_addr_seen[3]), 64'(exp_a));
        send(18'h1, 8'd5, 4'd3, 1'b0, '0);      // re-miss returns the written-back word
        wait_resp();

        rst = 1'b1; @(negedge clk); rst = 1'b0; model_reset();
        rbeat = -1;
        send(18'h7, 8'd9, 4'd2, 1'b0, '0);
        t = 0;
        while (rbeat != 7 && t < 500) begin @(negedge clk); #1; t++; end
        if (rbeat != 7) fail_msg("refill_beat7_timeout");
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs();
        @(negedge clk);
        model_reset();
        rst = 1'b0;
        send(18'h7, 8'd9, 4'd2, 1'b0, '0);      // same address must miss again
        wait_resp();

        for (int n = 0; n < 400; n++) begin
            logic [IDX-1:0] ix;
            ix = ($urandom_range(0, 3) == 0) ? IDX'($urandom_range(0, SETS - 1))
                                            : IDX'(5 + $urandom_range(0, 2));
            send(TB'($urandom_range(0, 5)), ix, OFF'($urandom_range(0, LW - 1)),
                 bit'($urandom_range(0, 1)), $urandom());
            wait_resp();
        end
        repeat (5) @(negedge clk);
        chk("final_memops_drained", 64'(mq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
